// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller:
// opcodes, funct codes, ALU operations, mux selects and FSM state codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b1010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;
    localparam logic [3:0] ALU_BEQ = 4'b1011;
    localparam logic [3:0] ALU_BNE = 4'b1101;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [3:0] S_RESET    = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_MEM_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WB   = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_ALU_WB   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU control: funct-driven R-type ops, opcode-driven
// immediate ops and the branch compare flavour.
module alu_op_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] r_alu_op,
    output logic       r_is_shift,
    output logic [3:0] i_alu_op,
    output logic [3:0] br_alu_op
);

    always_comb begin
        r_alu_op   = ALU_NOP;
        r_is_shift = 1'b0;
        case (funct)
            FN_ADD:  r_alu_op = ALU_ADD;
            FN_SUB:  r_alu_op = ALU_SUB;
            FN_AND:  r_alu_op = ALU_AND;
            FN_OR:   r_alu_op = ALU_OR;
            FN_SLL:  begin r_alu_op = ALU_SLL; r_is_shift = 1'b1; end
            FN_SRL:  begin r_alu_op = ALU_SRL; r_is_shift = 1'b1; end
            FN_SRA:  begin r_alu_op = ALU_SRA; r_is_shift = 1'b1; end
            default: r_alu_op = ALU_NOP;
        endcase
    end

    always_comb begin
        i_alu_op = ALU_ADD;
        case (opcode)
            OP_ANDI: i_alu_op = ALU_AND;
            OP_ORI:  i_alu_op = ALU_OR;
            default: i_alu_op = ALU_ADD;
        endcase
    end

    assign br_alu_op = (opcode == OP_BNE) ? ALU_BNE : ALU_BEQ;

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: one instruction at a time over a shared ALU
// and a single memory port, with a per-access mem_ready watchdog.
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       is_shift,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_retired,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [3:0] state
);

    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam int CW = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout;
    logic [3:0]    r_alu_op, i_alu_op, br_alu_op;
    logic          r_is_shift;

    alu_op_decode u_alu_op_decode (
        .opcode     (opcode),
        .funct      (funct),
        .r_alu_op   (r_alu_op),
        .r_is_shift (r_is_shift),
        .i_alu_op   (i_alu_op),
        .br_alu_op  (br_alu_op)
    );

    // A ready response in the final cycle beats the timeout.
    assign timeout = WD_EN && (cnt_q == CW'(TIMEOUT_CYCLES)) && !mem_ready;

    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_NOP;
        is_shift      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        instr_retired = 1'b0;
        illegal_instr = 1'b0;
        bus_error     = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    bus_error = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                alu_op    = ALU_ADD;
                case (opcode)
                    OP_RTYPE:                  state_d = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_EXEC_I;
                    OP_LW, OP_SW:              state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:            state_d = S_BRANCH;
                    OP_J:                      state_d = S_JUMP;
                    default: begin
                        illegal_instr = 1'b1;
                        state_d       = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = r_alu_op;
                is_shift  = r_is_shift;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = i_alu_op;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write     = 1'b1;
                reg_dst       = (opcode == OP_RTYPE);
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    bus_error = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end else if (timeout) begin
                    bus_error = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_MEM_WB: begin
                reg_write     = 1'b1;
                mem_to_reg    = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = br_alu_op;
                pc_src        = PC_ALUOUT;
                pc_write      = zero ^ (opcode == OP_BNE);
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write      = 1'b1;
                pc_src        = PC_JUMP;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Any state change (or a timed-out fetch retrying itself) restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q || bus_error) begin
            cnt_d = '0;
        end else if (WD_EN && mem_req && !mem_ready) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: instruction-level trace model with random
// instructions, operands and memory wait patterns.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a, is_shift, reg_write, reg_dst, mem_to_reg;
    logic [3:0] alu_op, state;
    logic       instr_retired, illegal_instr, bus_error;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       req, we, iord, irw, pcw;
        logic [1:0] pcs;
        logic       asa;
        logic [1:0] asb;
        logic [3:0] aop;
        logic       sh, rw, rd, m2r, ret, ill, berr;
    } obs_t;

    obs_t obs;
    obs_t exp_q[$];
    logic rdy_q[$];

    multicycle_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .is_shift      (is_shift),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .instr_retired (instr_retired),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .state         (state)
    );

    always #5 clk = ~clk;

    assign obs = {state, mem_req, mem_we, i_or_d, ir_write, pc_write,
                  pc_src, alu_src_a, alu_src_b, alu_op, is_shift,
                  reg_write, reg_dst, mem_to_reg, instr_retired,
                  illegal_instr, bus_error};

    function automatic obs_t blank(input logic [3:0] st);
        obs_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    task automatic check(input string tag, input int cyc, input obs_t e);
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s cyc%0d: got %h expected %h", tag, cyc, obs, e);
        end
    endtask

    task automatic push(input obs_t e, input logic r);
        exp_q.push_back(e);
        rdy_q.push_back(r);
    endtask

    // w = number of not-ready cycles before ready; w >= 5 means never ready.
    task automatic mem_phase(input logic [3:0] st, input int w, output bit ok);
        obs_t e;
        int stalls;
        e = blank(st);
        e.req = 1'b1;
        if (st == 4'd1) begin
            e.asb = 2'b01;
            e.aop = 4'b0010;
        end else begin
            e.iord = 1'b1;
            e.we = (st == 4'd8);
        end
        stalls = (w >= 5) ? 4 : w;
        for (int i = 0; i < stalls; i++) push(e, 1'b0);
        if (w >= 5) begin
            e.berr = 1'b1;
            push(e, 1'b0);
            ok = 1'b0;
        end else begin
            if (st == 4'd1) begin
                e.irw = 1'b1;
                e.pcw = 1'b1;
            end
            if (st == 4'd8) e.ret = 1'b1;
            push(e, 1'b1);
            ok = 1'b1;
        end
    endtask

    task automatic build(input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int wf, input int wm);
        obs_t e;
        bit ok;
        mem_phase(4'd1, wf, ok);
        if (!ok) return;
        e = blank(4'd2);
        e.asb = 2'b11;
        e.aop = 4'b0010;
        if (!(op inside {6'd0, 6'd8, 6'd12, 6'd13, 6'd35, 6'd43,
                         6'd4, 6'd5, 6'd2})) begin
            e.ill = 1'b1;
            push(e, 1'($urandom));
            return;
        end
        push(e, 1'($urandom));
        if (op == 6'd0 || op == 6'd8 || op == 6'd12 || op == 6'd13) begin
            if (op == 6'd0) begin
                e = blank(4'd3);
                e.asa = 1'b1;
                case (fn)
                    6'b100000: e.aop = 4'b0010;
                    6'b100010: e.aop = 4'b1010;
                    6'b100100: e.aop = 4'b0100;
                    6'b100101: e.aop = 4'b0101;
                    6'b000000: begin e.aop = 4'b0110; e.sh = 1'b1; end
                    6'b000010: begin e.aop = 4'b0111; e.sh = 1'b1; end
                    6'b000011: begin e.aop = 4'b1000; e.sh = 1'b1; end
                    default:   e.aop = 4'b0000;
                endcase
            end else begin
                e = blank(4'd4);
                e.asa = 1'b1;
                e.asb = 2'b10;
                e.aop = (op == 6'd8) ? 4'b0010 :
                        (op == 6'd12) ? 4'b0100 : 4'b0101;
            end
            push(e, 1'($urandom));
            e = blank(4'd9);
            e.rw = 1'b1;
            e.rd = (op == 6'd0);
            e.ret = 1'b1;
            push(e, 1'($urandom));
        end else if (op == 6'd35 || op == 6'd43) begin
            e = blank(4'd5);
            e.asa = 1'b1;
            e.asb = 2'b10;
            e.aop = 4'b0010;
            push(e, 1'($urandom));
            if (op == 6'd35) begin
                mem_phase(4'd6, wm, ok);
                if (ok) begin
                    e = blank(4'd7);
                    e.rw = 1'b1;
                    e.m2r = 1'b1;
                    e.ret = 1'b1;
                    push(e, 1'($urandom));
                end
            end else begin
                mem_phase(4'd8, wm, ok);
            end
        end else if (op == 6'd4 || op == 6'd5) begin
            e = blank(4'd10);
            e.asa = 1'b1;
            e.aop = (op == 6'd4) ? 4'b1011 : 4'b1101;
            e.pcs = 2'b01;
            e.pcw = (op == 6'd4) ? z : !z;
            e.ret = 1'b1;
            push(e, 1'($urandom));
        end else begin
            e = blank(4'd11);
            e.pcw = 1'b1;
            e.pcs = 2'b10;
            e.ret = 1'b1;
            push(e, 1'($urandom));
        end
    endtask

    // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 in
    // FETCH, or at the negedge of cycle `limit` when cut short.
    task automatic run(input string tag, input logic [5:0] op,
                       input logic [5:0] fn, input logic z,
                       input int wf, input int wm, input int limit);
        obs_t e;
        int n;
        exp_q.delete();
        rdy_q.delete();
        opcode = op;
        funct = fn;
        zero = z;
        build(op, fn, z, wf, wm);
        n = 0;
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            e = exp_q.pop_front();
            @(negedge clk);
            check(tag, n, e);
            n++;
            if (n == limit) break;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] t [11];
        t = '{6'd0, 6'd0, 6'd8, 6'd12, 6'd13, 6'd35, 6'd43,
              6'd4, 6'd5, 6'd2, 6'd63};
        if ($urandom_range(0, 11) == 11) return 6'($urandom);
        return t[$urandom_range(0, 10)];
    endfunction

    function automatic logic [5:0] pick_fn();
        logic [5:0] t [7];
        t = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
              6'b000000, 6'b000010, 6'b000011};
        if ($urandom_range(0, 7) == 7) return 6'($urandom);
        return t[$urandom_range(0, 6)];
    endfunction

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 0;
        if (r < 9) return $urandom_range(1, 4);
        return 5;
    endfunction

    initial begin
        rst_n = 1'b0;
        opcode = 6'd0;
        funct = 6'd0;
        zero = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release", 0, '0);
        @(posedge clk);
        #1;

        run("add", 6'd0, 6'b100000, 1'b0, 0, 0, 100);
        run("lw_wait3", 6'd35, 6'd0, 1'b0, 0, 3, 100);
        run("bne_z0", 6'd5, 6'd0, 1'b0, 0, 0, 100);
        run("beq_z0", 6'd4, 6'd0, 1'b0, 0, 0, 100);
        run("beq_z1", 6'd4, 6'd0, 1'b1, 0, 0, 100);
        run("illegal", 6'd63, 6'd0, 1'b0, 0, 0, 100);
        run("fetch_timeout", 6'd0, 6'b100000, 1'b0, 5, 0, 100);
        run("sra", 6'd0, 6'b000011, 1'b0, 0, 0, 100);
        run("lw_timeout", 6'd35, 6'd0, 1'b0, 0, 5, 100);
        run("sw_ready_at_limit", 6'd43, 6'd0, 1'b0, 4, 4, 100);
        run("jump", 6'd2, 6'd0, 1'b0, 0, 0, 100);

        for (int i = 0; i < 250; i++) begin
            run("random", pick_op(), pick_fn(), 1'($urandom),
                pick_wait(), pick_wait(), 100);
        end

        run("sw_pre_reset", 6'd43, 6'd0, 1'b0, 0, 3, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", 0, '0);
        @(posedge clk);
        #1;
        check("reset_low", 0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run("after_reset", 6'd13, 6'd0, 1'b0, 0, 0, 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
